// File: rtl/vram_pkg.sv
// Shared definitions for the display-memory arbiter: widths, SRAM cycle
// encoding and the posted-write entry layout.
package vram_pkg;

    localparam int AW         = 13;
    localparam int DW         = 8;
    localparam int WBUF_DEPTH = 4;
    localparam int PTR_W      = $clog2(WBUF_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TFT_RD   = 2'd1,
        HOST_RD  = 2'd2,
        WR_DRAIN = 2'd3
    } vram_st_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wentry_t;

endpackage

// File: rtl/vram_wbuf.sv
// Posted host-write FIFO. Pushes and pops are gated internally so that an
// illegal push while full or pop while empty never corrupts the count.
module vram_wbuf
    import vram_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  wentry_t wdata_i,
    input  logic    pop_i,
    output wentry_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    wentry_t          entries_q [WBUF_DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             pushOk;
    logic             popOk;

    assign full_o  = (count_q == CNT_W'(WBUF_DEPTH));
    assign empty_o = (count_q == '0);
    assign pushOk  = push_i & ~full_o;
    assign popOk   = pop_i & ~empty_o;
    assign head_o  = entries_q[rdPtr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (pushOk && !popOk) begin
                count_q <= count_q + 1'b1;
            end else if (popOk && !pushOk) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            entries_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/vram_arb.sv
// Single-port display SRAM arbiter: TFT fetch has absolute priority, host
// reads wait for an empty write buffer, posted writes drain in spare cycles.
module vram_arb
    import vram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          tft_rdreq,
    output logic          tft_rdack,
    input  logic [AW-1:0] tft_raddr,
    output logic [DW-1:0] tft_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    input  logic [DW-1:0] sram_din,
    output logic          sram_cs_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    vram_st_t      state_q;
    vram_st_t      state_d;
    logic [AW-1:0] sramAddr_q;
    logic [AW-1:0] sramAddr_d;
    logic [DW-1:0] sramDout_q;
    logic [DW-1:0] sramDout_d;
    logic          csN_q;
    logic          oeN_q;
    logic          weN_q;
    logic [DW-1:0] tftData_q;
    logic [DW-1:0] hostRdata_q;
    logic          hostRvalid_q;

    logic          wrAccept;
    logic          rdAccept;
    logic          rdPending;
    logic          wbufPop;
    logic          wbufFull;
    logic          wbufEmpty;
    wentry_t       wbufHead;
    wentry_t       wbufIn;

    assign wbufIn = '{addr: host_addr, data: host_wdata};

    vram_wbuf u_wbuf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wrAccept),
        .wdata_i (wbufIn),
        .pop_i   (wbufPop),
        .head_o  (wbufHead),
        .full_o  (wbufFull),
        .empty_o (wbufEmpty)
    );

    // Only one host read may be in its SRAM cycle at a time.
    assign rdPending = (state_q == HOST_RD);
    assign wrAccept  = host_req & host_we & ~wbufFull;
    assign rdAccept  = host_req & ~host_we & wbufEmpty & ~tft_rdreq & ~rdPending;
    assign host_ack  = wrAccept | rdAccept;
    assign tft_rdack = tft_rdreq;

    // Priority pick of the next SRAM cycle; a pre-empted drain simply stays
    // in the buffer and is picked again on the following edge.
    always_comb begin
        state_d    = IDLE;
        sramAddr_d = sramAddr_q;
        sramDout_d = sramDout_q;
        wbufPop    = 1'b0;
        if (tft_rdreq) begin
            state_d    = TFT_RD;
            sramAddr_d = tft_raddr;
        end else if (rdAccept) begin
            state_d    = HOST_RD;
            sramAddr_d = host_addr;
        end else if (!wbufEmpty) begin
            state_d    = WR_DRAIN;
            sramAddr_d = wbufHead.addr;
            sramDout_d = wbufHead.data;
            wbufPop    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sramAddr_q   <= '0;
            sramDout_q   <= '0;
            csN_q        <= 1'b1;
            oeN_q        <= 1'b1;
            weN_q        <= 1'b1;
            tftData_q    <= '0;
            hostRdata_q  <= '0;
            hostRvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sramAddr_q   <= sramAddr_d;
            sramDout_q   <= sramDout_d;
            csN_q        <= (state_d == IDLE);
            oeN_q        <= !((state_d == TFT_RD) || (state_d == HOST_RD));
            weN_q        <= (state_d != WR_DRAIN);
            hostRvalid_q <= (state_q == HOST_RD);
            if (state_q == TFT_RD) begin
                tftData_q <= sram_din;
            end
            if (state_q == HOST_RD) begin
                hostRdata_q <= sram_din;
            end
        end
    end

    // Fetch data is passed straight through during the fetch cycle itself.
    assign tft_rdata   = (state_q == TFT_RD) ? sram_din : tftData_q;
    assign host_rdata  = hostRdata_q;
    assign host_rvalid = hostRvalid_q;
    assign sram_addr   = sramAddr_q;
    assign sram_dout   = sramDout_q;
    assign sram_cs_n   = csN_q;
    assign sram_oe_n   = oeN_q;
    assign sram_we_n   = weN_q;

endmodule
